// File: rtl/sgt_max_scan.sv
// sgt_max_scan: framed signed running-maximum scanner with argmax; define SGT_MAX_SCAN_CNT_EN to add the O_cnt frame sample count
module sgt_max_scan #(
    parameter int WIDTH     = 2,
    parameter int IDX_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     I,
    input  logic                 I_valid,
    output logic                 I_ready,
    input  logic                 I_last,
    output logic [WIDTH-1:0]     O,
    output logic [IDX_WIDTH-1:0] O_idx,
    output logic                 O_valid,
    input  logic                 O_ready
`ifdef SGT_MAX_SCAN_CNT_EN
    ,
    output logic [IDX_WIDTH-1:0] O_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    localparam logic [IDX_WIDTH-1:0] ONE = 1;
    state_t               state;
    logic [IDX_WIDTH-1:0] pos;
    assign I_ready = (state != HOLD) & !RESET;
    // frame FSM: O doubles as the running maximum, only ties-or-less keep the earlier position
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            O       <= '0;
            O_idx   <= '0;
            O_valid <= 1'b0;
            pos     <= '0;
        end else begin
            case (state)
                IDLE: if (I_valid) begin
                    O       <= I;
                    O_idx   <= '0;
                    pos     <= ONE;
                    state   <= I_last ? HOLD : SCAN;
                    O_valid <= I_last;
                end
                SCAN: if (I_valid) begin
                    if ($signed(I) > $signed(O)) begin
                        O     <= I;
                        O_idx <= pos;
                    end
                    pos     <= pos + ONE;
                    state   <= I_last ? HOLD : SCAN;
                    O_valid <= I_last;
                end
                HOLD: if (O_ready) begin
                    state   <= IDLE;
                    O_valid <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    O_valid <= 1'b0;
                end
            endcase
        end
    end
`ifdef SGT_MAX_SCAN_CNT_EN
    // saturating count of samples accepted in the current frame
    always_ff @(posedge CLK) begin
        if (RESET)
            O_cnt <= '0;
        else if (I_valid && state == IDLE)
            O_cnt <= ONE;
        else if (I_valid && state == SCAN)
            O_cnt <= (O_cnt == '1) ? O_cnt : O_cnt + ONE;
    end
`endif
endmodule

// File: tb/tb_sgt_max_scan.sv
// tb_sgt_max_scan: directed frames against a whole-frame argmax model plus literal spot checks
module tb_sgt_max_scan;
    logic       CLK;
    logic       RESET;
    logic [1:0] I;
    logic       I_valid;
    logic       I_ready;
    logic       I_last;
    logic [1:0] O;
    logic [1:0] O_idx;
    logic       O_valid;
    logic       O_ready;
`ifdef SGT_MAX_SCAN_CNT_EN
    logic [1:0] O_cnt;
`endif

    int errors = 0;
    int checks = 0;

    sgt_max_scan #(.WIDTH(2), .IDX_WIDTH(2)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .I(I),
        .I_valid(I_valid),
        .I_ready(I_ready),
        .I_last(I_last),
        .O(O),
        .O_idx(O_idx),
        .O_valid(O_valid),
        .O_ready(O_ready)
`ifdef SGT_MAX_SCAN_CNT_EN
        ,
        .O_cnt(O_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // model: collect the whole frame, pick the earliest maximum when the last sample arrives
    logic [1:0] q[$];
    logic       m_hold = 1'b0;
    logic       m_init = 1'b0;
    int         exp_o = 0;
    int         exp_idx = 0;
    int         exp_cnt = 0;
    int         best;

    always @(posedge CLK) begin
        if (RESET) begin
            m_init  = 1'b1;
            m_hold  = 1'b0;
            q.delete();
            exp_o   = 0;
            exp_idx = 0;
            exp_cnt = 0;
        end else if (m_hold) begin
            if (O_ready) m_hold = 1'b0;
        end else if (I_valid) begin
            q.push_back(I);
            if (I_last) begin
                best = 0;
                for (int k = 1; k < q.size(); k++)
                    if ($signed(q[k]) > $signed(q[best])) best = k;
                exp_o   = int'(q[best]);
                exp_idx = best % 4;
                exp_cnt = (q.size() > 3) ? 3 : q.size();
                m_hold  = 1'b1;
                q.delete();
            end
        end
    end

    always @(negedge CLK) begin
        if (m_init) begin
            chk("I_ready", int'(I_ready), int'(!m_hold && !RESET));
            chk("O_valid", int'(O_valid), int'(m_hold));
            if (q.size() == 0) begin
                chk("O", int'(O), exp_o);
                chk("O_idx", int'(O_idx), exp_idx);
`ifdef SGT_MAX_SCAN_CNT_EN
                chk("O_cnt", int'(O_cnt), exp_cnt);
`endif
            end
        end
    end

    task automatic cyc(input logic v, input logic [1:0] d, input logic l);
        @(posedge CLK);
        #1;
        I_valid = v;
        I       = d;
        I_last  = l;
    endtask

    initial begin
        RESET = 1'b1; I = '0; I_valid = 1'b0; I_last = 1'b0; O_ready = 1'b1;
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        chk("rst I_ready", int'(I_ready), 0);
        chk("rst O_valid", int'(O_valid), 0);
        chk("rst O", int'(O), 0);
        cyc(0, 2'b00, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post-rst I_ready", int'(I_ready), 1);
        // signedness: 1, -2, -1 -> max 1 at 0
        cyc(1, 2'b01, 0);
        cyc(1, 2'b10, 0);
        cyc(1, 2'b11, 1);
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        chk("sign O_valid", int'(O_valid), 1);
        chk("sign O", int'(O), 1);
        chk("sign O_idx", int'(O_idx), 0);
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        chk("sign O_valid drop", int'(O_valid), 0);
        chk("sign I_ready back", int'(I_ready), 1);
        // ties, gaps and backpressure: -2, 1, gap, 0, 1 -> max 1 at 1
        O_ready = 1'b0;
        cyc(1, 2'b10, 0);
        cyc(1, 2'b01, 0);
        for (int g = 0; g < 3; g++) cyc(0, 2'b00, 0);
        cyc(1, 2'b00, 0);
        cyc(1, 2'b01, 1);
        for (int b = 0; b < 5; b++) begin
            cyc(b[0], 2'b01, b[0]);
            @(negedge CLK);
            chk("bp O_valid", int'(O_valid), 1);
            chk("bp O", int'(O), 1);
            chk("bp O_idx", int'(O_idx), 1);
            chk("bp I_ready", int'(I_ready), 0);
        end
        cyc(0, 2'b00, 0);
        O_ready = 1'b1;
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        chk("bp release O_valid", int'(O_valid), 0);
        chk("bp release I_ready", int'(I_ready), 1);
        // single-sample frame {-1}
        cyc(1, 2'b11, 1);
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        chk("single O_valid", int'(O_valid), 1);
        chk("single O", int'(O), 3);
        chk("single O_idx", int'(O_idx), 0);
        cyc(0, 2'b00, 0);
        // wrap: -2 x5, 1 -> index 5 mod 4 = 1
        for (int w = 0; w < 5; w++) cyc(1, 2'b10, 0);
        cyc(1, 2'b01, 1);
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        chk("wrap O_valid", int'(O_valid), 1);
        chk("wrap O", int'(O), 1);
        chk("wrap O_idx", int'(O_idx), 1);
`ifdef SGT_MAX_SCAN_CNT_EN
        chk("wrap O_cnt", int'(O_cnt), 3);
`endif
        cyc(0, 2'b00, 0);
        // reset mid-frame drops the partial maximum
        cyc(1, 2'b01, 0);
        cyc(1, 2'b11, 0);
        cyc(0, 2'b00, 0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst I_ready", int'(I_ready), 0);
        cyc(0, 2'b00, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("midrst O_valid", int'(O_valid), 0);
        chk("midrst O", int'(O), 0);
        cyc(1, 2'b10, 1);
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        chk("after rst O_valid", int'(O_valid), 1);
        chk("after rst O", int'(O), 2);
        chk("after rst O_idx", int'(O_idx), 0);
        cyc(0, 2'b00, 0);
        cyc(0, 2'b00, 0);
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
